// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU retire-trace monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    // Instruction words that end a program run
    localparam logic [31:0] ECALL_INSN    = 32'h0000_0073;
    localparam logic [31:0] JAL_SELF_INSN = 32'h0000_006f;  // jal x0,0

    // Run-control states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    // Reason the monitor left RUN; timeout and external stop share a code
    typedef enum logic [1:0] {
        HC_NONE  = 2'd0,
        HC_ECALL = 2'd1,
        HC_SELF  = 2'd2,
        HC_STOP  = 2'd3
    } halt_cause_t;

    // Default-width trace entry layout (XLEN=32, RADDR_W=5); the top builds
    // the same field order with its own parameter widths
    localparam int TR_XLEN    = 32;
    localparam int TR_RADDR_W = 5;

    typedef struct packed {
        logic [TR_XLEN-1:0]    pc;
        logic [31:0]           instr;
        logic                  we;
        logic [TR_RADDR_W-1:0] rd;
        logic [TR_XLEN-1:0]    wdata;
    } trace_entry_t;

endpackage

// File: rtl/cpu_trace_monitor_fifo.sv
// Generic synchronous FIFO with valid/ready on both sides and exact occupancy.
// Latency: a write at edge k is readable (out_vld/out_dat) right after edge k.
// Backpressure: in_rdy drops when full unless a pop happens in the same cycle.
module trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [W-1:0]             in_dat,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [W-1:0]             out_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_fire;
    logic          rd_fire;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign out_vld = !empty;
    assign out_dat = mem[rd_ptr];
    assign rd_fire = out_vld && out_rdy;
    // A full FIFO still accepts when the head leaves in the same cycle
    assign in_rdy  = !full || rd_fire;
    assign wr_fire = in_vld && in_rdy;

    // Storage write; contents are don't-care until pointers say otherwise
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two); count tracks both
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_trace_monitor.sv
// Retire-trace recorder plus run-control FSM (IDLE/RUN/HALT) with counters.
// Latency: a retirement at edge k is on tr_* after edge k; halt seen next edge.
// Backpressure: tr_valid/tr_ready; retirements arriving while full are dropped and counted.
module cpu_trace_monitor
    import cpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     ret_valid,
    input  logic [XLEN-1:0]          ret_pc,
    input  logic [31:0]              ret_instr,
    input  logic                     ret_we,
    input  logic [RADDR_W-1:0]       ret_rd,
    input  logic [XLEN-1:0]          ret_wdata,
    output logic                     tr_valid,
    input  logic                     tr_ready,
    output logic [XLEN-1:0]          tr_pc,
    output logic [31:0]              tr_instr,
    output logic                     tr_we,
    output logic [RADDR_W-1:0]       tr_rd,
    output logic [XLEN-1:0]          tr_wdata,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [CNT_W-1:0]         retire_count,
    output logic                     running,
    output logic                     halted,
    output logic [1:0]               halt_cause
);

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [31:0]        instr;
        logic               we;
        logic [RADDR_W-1:0] rd;
        logic [XLEN-1:0]    wdata;
    } entry_t;

    localparam int EW = $bits(entry_t);
    // Last RUN cycle before a forced halt; unused when TIMEOUT is 0
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t      state;
    halt_cause_t cause_q;
    halt_cause_t cause_nxt;
    logic        halt_req;
    logic        in_run;
    logic        restart;
    logic        push_vld;
    logic        push_rdy;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop_fire;
    logic        drop;
    entry_t      push_dat;
    entry_t      head_dat;

    assign in_run  = (state == S_RUN);
    assign restart = start && !in_run;

    // Halt detection with priority ecall > self-loop > timeout > stop
    always_comb begin
        halt_req  = 1'b0;
        cause_nxt = HC_NONE;
        if (in_run) begin
            if (ret_valid && ret_instr == ECALL_INSN) begin
                halt_req  = 1'b1;
                cause_nxt = HC_ECALL;
            end else if (ret_valid && ret_instr == JAL_SELF_INSN) begin
                halt_req  = 1'b1;
                cause_nxt = HC_SELF;
            end else if ((TIMEOUT != 0) && (cycle_count == TO_LAST)) begin
                halt_req  = 1'b1;
                cause_nxt = HC_STOP;
            end else if (stop) begin
                halt_req  = 1'b1;
                cause_nxt = HC_STOP;
            end
        end
    end

    // Run-control FSM; halt_cause is latched on the halting edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cause_q <= HC_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_RUN;
                        cause_q <= HC_NONE;
                    end
                end
                S_RUN: begin
                    if (halt_req) begin
                        state   <= S_HALT;
                        cause_q <= cause_nxt;
                    end
                end
                S_HALT: begin
                    if (start) begin
                        state   <= S_RUN;
                        cause_q <= HC_NONE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cause_q <= HC_NONE;
                end
            endcase
        end
    end

    assign running    = (state == S_RUN);
    assign halted     = (state == S_HALT);
    assign halt_cause = cause_q;

    // Only retirements seen in RUN are traced; x0 writes are recorded as no-write
    always_comb begin
        push_vld       = ret_valid && in_run;
        push_dat.pc    = ret_pc;
        push_dat.instr = ret_instr;
        push_dat.we    = ret_we && (ret_rd != '0);
        push_dat.rd    = ret_rd;
        push_dat.wdata = ret_wdata;
    end

    assign pop_fire = !fifo_empty && tr_ready;
    assign drop     = push_vld && fifo_full && !pop_fire;

    trace_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (push_vld),
        .in_rdy  (push_rdy),
        .in_dat  (push_dat),
        .out_vld (tr_valid),
        .out_rdy (tr_ready),
        .out_dat (head_dat),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign tr_pc    = head_dat.pc;
    assign tr_instr = head_dat.instr;
    assign tr_we    = head_dat.we;
    assign tr_rd    = head_dat.rd;
    assign tr_wdata = head_dat.wdata;

    // Cycle and retire counters: cleared on (re)start, saturating in RUN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count  <= '0;
            retire_count <= '0;
        end else if (restart) begin
            cycle_count  <= '0;
            retire_count <= '0;
        end else if (in_run) begin
            if (!(&cycle_count)) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (ret_valid && !(&retire_count)) begin
                retire_count <= retire_count + 1'b1;
            end
        end
    end

    // Drop accounting for pushes refused by a full FIFO (push_rdy low)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (restart) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop && !push_rdy) begin
            overflow <= 1'b1;
            if (!(&drop_count)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed bench for cpu_trace_monitor with hand-computed expectations.
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns after posedge.
// Backpressure: tr_ready driven explicitly per scenario.
module tb_cpu_trace_monitor;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 50;
    localparam int CNT_W   = 32;

    logic               clk;
    logic               rst;
    logic               start;
    logic               stop;
    logic               ret_valid;
    logic [XLEN-1:0]    ret_pc;
    logic [31:0]        ret_instr;
    logic               ret_we;
    logic [RADDR_W-1:0] ret_rd;
    logic [XLEN-1:0]    ret_wdata;
    logic               tr_valid;
    logic               tr_ready;
    logic [XLEN-1:0]    tr_pc;
    logic [31:0]        tr_instr;
    logic               tr_we;
    logic [RADDR_W-1:0] tr_rd;
    logic [XLEN-1:0]    tr_wdata;
    logic [$clog2(DEPTH):0] fifo_count;
    logic               overflow;
    logic [CNT_W-1:0]   drop_count;
    logic [CNT_W-1:0]   cycle_count;
    logic [CNT_W-1:0]   retire_count;
    logic               running;
    logic               halted;
    logic [1:0]         halt_cause;

    int n_checks = 0;
    int n_pass   = 0;

    cpu_trace_monitor #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .ret_valid    (ret_valid),
        .ret_pc       (ret_pc),
        .ret_instr    (ret_instr),
        .ret_we       (ret_we),
        .ret_rd       (ret_rd),
        .ret_wdata    (ret_wdata),
        .tr_valid     (tr_valid),
        .tr_ready     (tr_ready),
        .tr_pc        (tr_pc),
        .tr_instr     (tr_instr),
        .tr_we        (tr_we),
        .tr_rd        (tr_rd),
        .tr_wdata     (tr_wdata),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .cycle_count  (cycle_count),
        .retire_count (retire_count),
        .running      (running),
        .halted       (halted),
        .halt_cause   (halt_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        stop      = 1'b0;
        ret_valid = 1'b0;
        ret_pc    = '0;
        ret_instr = 32'h0000_0013;
        ret_we    = 1'b0;
        ret_rd    = '0;
        ret_wdata = '0;
        tr_ready  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] instr,
                          input logic [4:0] rd, input logic [31:0] wd);
        ret_valid = 1'b1;
        ret_pc    = pc;
        ret_instr = instr;
        ret_we    = 1'b1;
        ret_rd    = rd;
        ret_wdata = wd;
        tick();
        ret_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();

        // Reset state
        tick();
        check_eq("rst_tr_valid", 64'(tr_valid), 64'd0);
        check_eq("rst_count", 64'(fifo_count), 64'd0);
        check_eq("rst_running", 64'(running), 64'd0);
        check_eq("rst_halted", 64'(halted), 64'd0);
        check_eq("rst_cause", 64'(halt_cause), 64'd0);
        check_eq("rst_cycles", 64'(cycle_count), 64'd0);
        check_eq("rst_overflow", 64'(overflow), 64'd0);

        // Three retirements streamed with tr_ready=1
        do_reset();
        do_start();
        check_eq("t1_running", 64'(running), 64'd1);
        tr_ready = 1'b1;
        retire(32'd0, 32'h0050_0513, 5'd10, 32'd5);
        check_eq("t1_e0_pc", 64'(tr_pc), 64'd0);
        check_eq("t1_e0_we", 64'(tr_we), 64'd1);
        check_eq("t1_e0_rd", 64'(tr_rd), 64'd10);
        check_eq("t1_e0_wd", 64'(tr_wdata), 64'd5);
        retire(32'd4, 32'h0070_0593, 5'd11, 32'd7);
        check_eq("t1_e1_pc", 64'(tr_pc), 64'd4);
        check_eq("t1_e1_rd", 64'(tr_rd), 64'd11);
        check_eq("t1_e1_count", 64'(fifo_count), 64'd1);
        retire(32'd8, 32'h0090_0013, 5'd0, 32'd9);
        check_eq("t1_e2_pc", 64'(tr_pc), 64'd8);
        check_eq("t1_e2_we", 64'(tr_we), 64'd0);
        check_eq("t1_e2_wd", 64'(tr_wdata), 64'd9);
        check_eq("t1_retires", 64'(retire_count), 64'd3);
        tick();
        check_eq("t1_drained", 64'(tr_valid), 64'd0);

        // Overflow: 20 retirements into 16 entries, then push+pop while full
        do_reset();
        do_start();
        tr_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            retire(32'(i * 4), 32'h0000_0013, 5'd1, 32'(i));
        end
        check_eq("ov_count", 64'(fifo_count), 64'd16);
        check_eq("ov_flag", 64'(overflow), 64'd1);
        check_eq("ov_drops", 64'(drop_count), 64'd4);
        check_eq("ov_head", 64'(tr_pc), 64'd0);
        tr_ready = 1'b1;
        retire(32'h1000, 32'h0000_0013, 5'd2, 32'hAA);
        check_eq("pp_count", 64'(fifo_count), 64'd16);
        check_eq("pp_drops", 64'(drop_count), 64'd4);
        check_eq("pp_retires", 64'(retire_count), 64'd21);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] exp_pc;
            exp_pc = (i < 15) ? 32'((i + 1) * 4) : 32'h1000;
            check_eq($sformatf("drain_pc%0d", i), 64'(tr_pc), 64'(exp_pc));
            tick();
        end
        check_eq("drain_empty", 64'(fifo_count), 64'd0);
        tr_ready = 1'b0;

        // ecall at RUN cycle 5, then retirements while halted are ignored
        do_reset();
        do_start();
        repeat (5) tick();
        retire(32'h40, 32'h0000_0073, 5'd0, 32'd0);
        check_eq("ec_halted", 64'(halted), 64'd1);
        check_eq("ec_cause", 64'(halt_cause), 64'd1);
        check_eq("ec_count", 64'(fifo_count), 64'd1);
        check_eq("ec_instr", 64'(tr_instr), 64'h73);
        check_eq("ec_cycles", 64'(cycle_count), 64'd6);
        retire(32'h44, 32'h0000_0013, 5'd3, 32'd1);
        retire(32'h48, 32'h0000_0013, 5'd3, 32'd2);
        check_eq("ec_ign_count", 64'(fifo_count), 64'd1);
        check_eq("ec_ign_ret", 64'(retire_count), 64'd1);
        do_start();
        check_eq("ec_restart_run", 64'(running), 64'd1);
        check_eq("ec_restart_cause", 64'(halt_cause), 64'd0);
        check_eq("ec_restart_fifo", 64'(fifo_count), 64'd1);

        // Self-loop halts with cause 2
        do_reset();
        do_start();
        retire(32'h80, 32'h0000_006f, 5'd0, 32'd0);
        check_eq("sl_halted", 64'(halted), 64'd1);
        check_eq("sl_cause", 64'(halt_cause), 64'd2);

        // ecall beats a simultaneous stop
        do_reset();
        do_start();
        stop = 1'b1;
        retire(32'h90, 32'h0000_0073, 5'd0, 32'd0);
        stop = 1'b0;
        check_eq("pri_cause", 64'(halt_cause), 64'd1);

        // External stop alone
        do_reset();
        do_start();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("stop_halted", 64'(halted), 64'd1);
        check_eq("stop_cause", 64'(halt_cause), 64'd3);

        // Timeout after exactly 50 RUN cycles, then restart clears counters
        do_reset();
        do_start();
        repeat (49) tick();
        check_eq("to_still_run", 64'(running), 64'd1);
        check_eq("to_cyc49", 64'(cycle_count), 64'd49);
        tick();
        check_eq("to_halted", 64'(halted), 64'd1);
        check_eq("to_cause", 64'(halt_cause), 64'd3);
        check_eq("to_cyc50", 64'(cycle_count), 64'd50);
        tick();
        check_eq("to_cyc_hold", 64'(cycle_count), 64'd50);
        do_start();
        check_eq("to_rerun", 64'(running), 64'd1);
        check_eq("to_rerun_cyc", 64'(cycle_count), 64'd0);
        check_eq("to_rerun_cause", 64'(halt_cause), 64'd0);

        // Asynchronous reset mid-run with 5 entries queued
        do_reset();
        do_start();
        for (int i = 0; i < 5; i++) begin
            retire(32'(i * 4), 32'h0000_0013, 5'd4, 32'(i));
        end
        check_eq("ar_pre_count", 64'(fifo_count), 64'd5);
        #2;
        rst = 1'b0;
        #1;
        check_eq("ar_tr_valid", 64'(tr_valid), 64'd0);
        check_eq("ar_count", 64'(fifo_count), 64'd0);
        check_eq("ar_running", 64'(running), 64'd0);
        check_eq("ar_halted", 64'(halted), 64'd0);
        check_eq("ar_retires", 64'(retire_count), 64'd0);
        tick();
        rst = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
